// File: rtl/riscv_controller.sv
// riscv_controller
//   Sequencing controller for the VeriRISC datapath. A 3-bit phase counter
//   walks an 8-phase instruction cycle. The current phase, the opcode and the
//   accumulator zero flag are decoded combinationally into the datapath
//   control strobes. The phase register is the only state in the block.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset (0 = reset)
//   opcode  in   [2:0] opcode field from the instruction register
//   zero    in   accumulator-is-zero flag
//   phase   out  [2:0] current phase (registered, doubles as FSM state debug)
//   sel     out  address mux select: 1 = PC, 0 = IR operand
//   rd      out  memory read enable
//   ld_ir   out  instruction register write enable
//   halt    out  processor halted
//   inc_pc  out  program counter increment
//   ld_ac   out  accumulator write enable
//   ld_pc   out  program counter load (jump)
//   wr      out  memory write enable
//   data_e  out  accumulator-to-data-bus driver enable
//
// There is no valid/ready handshake: the block free-runs one phase per clock.
module riscv_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t state_q;
  phase_t state_d;

  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;
  logic alu_op;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  assign phase = state_q;

  // Asynchronous reset so strobes of an aborted instruction (notably wr and
  // ld_ac in STORE) drop the instant reset is asserted, not at the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = phase_t'(state_q + 3'd1);
    sel     = 1'b0;
    rd      = 1'b0;
    ld_ir   = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    ld_ac   = 1'b0;
    ld_pc   = 1'b0;
    wr      = 1'b0;
    data_e  = 1'b0;
    unique case (state_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        // HLT parks here; inc_pc stays high and the PC stage gates it with halt.
        inc_pc = 1'b1;
        halt   = is_hlt;
        if (is_hlt) state_d = OP_ADDR;
      end
      OP_FETCH: begin
        rd = alu_op;
      end
      ALU_OP: begin
        rd     = alu_op;
        inc_pc = is_skz && zero;  // second increment skips the next word
        ld_pc  = is_jmp;
        data_e = is_sto;          // bus set up one phase ahead of wr
      end
      STORE: begin
        rd     = alu_op;
        ld_ac  = alu_op;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
      default: begin
        state_d = INST_ADDR;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_controller.sv
// tb_riscv_controller
//   Directed bench for riscv_controller. Expected strobe patterns are
//   hand-written per phase as 9-bit words in the order
//   {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}.
module tb_riscv_controller;

  logic       clk;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;

  logic [8:0] outs;
  assign outs = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

  int n_checks = 0;
  int n_errors = 0;

  riscv_controller dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .halt   (halt),
    .inc_pc (inc_pc),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .wr     (wr),
    .data_e (data_e)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change 2 time units after the rising edge, outputs sampled there.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Common instruction-fetch phases 0..3.
  localparam logic [8:0] P0 = 9'b100000000;
  localparam logic [8:0] P1 = 9'b110000000;
  localparam logic [8:0] P2 = 9'b111000000;
  localparam logic [8:0] P3 = 9'b111000000;

  // Checks phases 0..last against tbl (phase 0 in the top 9 bits), stepping
  // one clock after each phase. Expects to be entered in phase 0.
  task automatic run_phases(input string tag, input logic [2:0] op, input logic z,
                            input logic [71:0] tbl, input int last);
    opcode = op;
    zero   = z;
    #1;
    for (int p = 0; p <= last; p++) begin
      check($sformatf("%s_phase%0d", tag, p), 32'(phase), 32'(p));
      check($sformatf("%s_outs%0d", tag, p), 32'(outs), 32'(tbl[(7-p)*9 +: 9]));
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    #1;
    check("rst_async_phase", 32'(phase), 32'd0);
    step();
    step();
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_outs", 32'(outs), 32'(9'b100000000));

    reset = 1'b1;
    // ADD: ld_ir in 2-3, inc_pc in 4, rd in 1,2,3,5,6,7, ld_ac in 7.
    run_phases("add", 3'd2, 1'b0,
               {P0, P1, P2, P3, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000}, 7);
    check("wrap_phase", 32'(phase), 32'd0);
    // ALUOP decode for AND/XOR/LDA matches ADD; zero ignored.
    run_phases("and", 3'd3, 1'b1,
               {P0, P1, P2, P3, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000}, 7);
    run_phases("xor", 3'd4, 1'b0,
               {P0, P1, P2, P3, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000}, 7);
    run_phases("lda", 3'd5, 1'b0,
               {P0, P1, P2, P3, 9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000}, 7);
    // SKZ: second inc_pc only in phase 6 when zero=1.
    run_phases("skz_z1", 3'd1, 1'b1,
               {P0, P1, P2, P3, 9'b000010000, 9'b000000000, 9'b000010000, 9'b000000000}, 7);
    run_phases("skz_z0", 3'd1, 1'b0,
               {P0, P1, P2, P3, 9'b000010000, 9'b000000000, 9'b000000000, 9'b000000000}, 7);
    // STO: data_e in 6-7, wr in 7 only.
    run_phases("sto", 3'd6, 1'b0,
               {P0, P1, P2, P3, 9'b000010000, 9'b000000000, 9'b000000001, 9'b000000011}, 7);
    // JMP: ld_pc in 6-7, no rd.
    run_phases("jmp", 3'd7, 1'b1,
               {P0, P1, P2, P3, 9'b000010000, 9'b000000000, 9'b000000100, 9'b000000100}, 7);

    // HLT: halt from phase 4, then frozen.
    run_phases("hlt", 3'd0, 1'b0,
               {P0, P1, P2, P3, 9'b000110000, 27'd0}, 4);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hlt_hold_phase%0d", i), 32'(phase), 32'd4);
      check($sformatf("hlt_hold_outs%0d", i), 32'(outs), 32'(9'b000110000));
      step();
    end
    reset = 1'b0;
    #1;
    check("hlt_rst_phase", 32'(phase), 32'd0);
    check("hlt_rst_outs", 32'(outs), 32'(9'b100000000));
    step();
    reset = 1'b1;

    // Mid-operation reset during STO phase 7.
    run_phases("sto_mid", 3'd6, 1'b0,
               {P0, P1, P2, P3, 9'b000010000, 9'b000000000, 9'b000000001, 9'd0}, 6);
    check("mid_pre_phase", 32'(phase), 32'd7);
    check("mid_pre_wr_de", 32'({wr, data_e}), 32'(2'b11));
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_phase", 32'(phase), 32'd0);
    check("mid_rst_wr_de", 32'({wr, data_e}), 32'(2'b00));
    check("mid_rst_outs", 32'(outs), 32'(9'b100000000));
    step();
    check("mid_rst_hold", 32'(phase), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rel_phase", 32'(phase), 32'd0);
    step();
    check("mid_restart_p1", 32'(phase), 32'd1);
    step();
    check("mid_restart_p2", 32'(phase), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
